channel_deserializer_16: RTL and testbench

- Producer-side front end for the 16-channel 3x3 convolution engine.
- Accepts one channel-interleaved word per cycle (pixel p: ch0, ch1, ..., ch15, then pixel p+1).
- Gathers each pixel's CHANNEL words, then presents all lanes at once as 16 parallel channel streams with a one-cycle data_valid_out strobe, which drives the engine's data_valid_in.
- Tracks pixel position in the frame and flags the last pixel with done.

---
 rtl/channel_deserializer_16_pkg.sv | 27 ++
 rtl/channel_deserializer_16_if.sv | 24 ++
 rtl/channel_deserializer_16_frame_pixel_counter.sv | 52 +++++
 rtl/channel_deserializer_16.sv | 175 +++++++++++++++++
 tb/tb_channel_deserializer_16.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/channel_deserializer_16_pkg.sv
// Shared definitions for the channel deserializer and the convolution engines:
// lane count, the FP32 word type and the counter width helpers.
package channel_deserializer_16_pkg;

    localparam int MAX_LANES = 16;

    typedef logic [31:0] fp32_t;

    // Smallest width able to index n values; never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < n) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

    function automatic int ch_cnt_w(input int channel);
        return clog2_min1(channel);
    endfunction

    function automatic int pix_cnt_w(input int img_width, input int img_height);
        return clog2_min1(img_width * img_height);
    endfunction

endpackage

// File: rtl/channel_deserializer_16_if.sv
// Channel-interleaved input stream: one channel word per valid cycle,
// with an optional sync marker on channel-0 words.
interface channel_deserializer_16_if
    import channel_deserializer_16_pkg::*;
#(
    parameter int DATA_WIDTH = $bits(fp32_t)
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_first;

    modport master (
        output in_valid,
        output in_data,
        output in_first
    );

    modport slave (
        input in_valid,
        input in_data,
        input in_first
    );

endinterface

// File: rtl/channel_deserializer_16_frame_pixel_counter.sv
// Pixel position within a frame; raises done alongside the strobe of the
// final pixel and wraps so consecutive frames need no idle gap.
module channel_deserializer_16_frame_pixel_counter
    import channel_deserializer_16_pkg::*;
#(
    parameter int IMG_WIDTH  = 56,
    parameter int IMG_HEIGHT = 56
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic strobe,
    output logic done
);

    localparam int PIX_CNT_W = pix_cnt_w(IMG_WIDTH, IMG_HEIGHT);
    localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(IMG_WIDTH * IMG_HEIGHT - 32'sd1);
    localparam logic [PIX_CNT_W-1:0] PIX_ONE  = PIX_CNT_W'(1'b1);

    logic [PIX_CNT_W-1:0] pix_cnt_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q;
    logic                 done_d;
    logic                 done_q;

    // Next pixel position and done flag
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        done_d    = 1'b0;
        if (clear) begin
            pix_cnt_d = '0;
        end else if (strobe) begin
            done_d    = (pix_cnt_q == LAST_PIX);
            pix_cnt_d = (pix_cnt_q == LAST_PIX) ? '0 : (pix_cnt_q + PIX_ONE);
        end else begin
            pix_cnt_d = pix_cnt_q;
        end
    end

    // Counter and done registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            done_q    <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/channel_deserializer_16.sv
// Gathers CHANNEL interleaved words per pixel into a shadow bank and presents
// them as 16 parallel lanes with a one-cycle data_valid_out strobe.
module channel_deserializer_16
    import channel_deserializer_16_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 56,
    parameter int IMG_HEIGHT = 56,
    parameter int CHANNEL    = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    channel_deserializer_16_if.slave in_if,
    output logic [DATA_WIDTH-1:0] data_out_0,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic [DATA_WIDTH-1:0] data_out_2,
    output logic [DATA_WIDTH-1:0] data_out_3,
    output logic [DATA_WIDTH-1:0] data_out_4,
    output logic [DATA_WIDTH-1:0] data_out_5,
    output logic [DATA_WIDTH-1:0] data_out_6,
    output logic [DATA_WIDTH-1:0] data_out_7,
    output logic [DATA_WIDTH-1:0] data_out_8,
    output logic [DATA_WIDTH-1:0] data_out_9,
    output logic [DATA_WIDTH-1:0] data_out_10,
    output logic [DATA_WIDTH-1:0] data_out_11,
    output logic [DATA_WIDTH-1:0] data_out_12,
    output logic [DATA_WIDTH-1:0] data_out_13,
    output logic [DATA_WIDTH-1:0] data_out_14,
    output logic [DATA_WIDTH-1:0] data_out_15,
    output logic                  data_valid_out,
    output logic                  done,
    output logic                  busy,
    output logic                  sync_err
);

    localparam int CH_CNT_W = ch_cnt_w(CHANNEL);
    localparam logic [CH_CNT_W-1:0] LAST_CH = CH_CNT_W'(CHANNEL - 32'sd1);
    localparam logic [CH_CNT_W-1:0] CH_ONE  = CH_CNT_W'(1'b1);

    logic [CH_CNT_W-1:0]   ch_cnt_d;
    logic [CH_CNT_W-1:0]   ch_cnt_q;
    logic [DATA_WIDTH-1:0] shadow_d [CHANNEL];
    logic [DATA_WIDTH-1:0] shadow_q [CHANNEL];
    logic [DATA_WIDTH-1:0] lane_d   [MAX_LANES];
    logic [DATA_WIDTH-1:0] lane_q   [MAX_LANES];
    logic                  pending_d;
    logic                  pending_q;
    logic                  valid_d;
    logic                  valid_q;
    logic                  busy_d;
    logic                  busy_q;
    logic                  sync_err_d;
    logic                  sync_err_q;
    logic                  accept;
    logic                  resync;
    logic                  complete;
    logic                  strobe;

    // Word acceptance, resync on a misplaced marker, and channel counter
    always_comb begin
        accept   = in_if.in_valid & ~clear;
        resync   = accept & in_if.in_first & (ch_cnt_q != '0);
        complete = accept & ~resync & (ch_cnt_q == LAST_CH);
        strobe   = pending_q & ~clear;
        ch_cnt_d = ch_cnt_q;
        if (clear) begin
            ch_cnt_d = '0;
        end else if (resync) begin
            ch_cnt_d = CH_ONE;
        end else if (complete) begin
            ch_cnt_d = '0;
        end else if (accept) begin
            ch_cnt_d = ch_cnt_q + CH_ONE;
        end else begin
            ch_cnt_d = ch_cnt_q;
        end
    end

    // Shadow writes, lane loading, and status flags
    always_comb begin
        for (int i = 0; i < CHANNEL; i++) begin
            if (resync) begin
                shadow_d[i] = (i == 32'sd0) ? in_if.in_data : shadow_q[i];
            end else if (accept && (ch_cnt_q == CH_CNT_W'(i))) begin
                shadow_d[i] = in_if.in_data;
            end else begin
                shadow_d[i] = shadow_q[i];
            end
        end
        // Lanes beyond CHANNEL load zero, so they stay zero for good.
        for (int i = 0; i < MAX_LANES; i++) begin
            lane_d[i] = strobe ? '0 : lane_q[i];
        end
        for (int i = 0; i < CHANNEL; i++) begin
            if (strobe) begin
                lane_d[i] = shadow_q[i];
            end else begin
                lane_d[i] = lane_q[i];
            end
        end
        pending_d  = complete;
        valid_d    = strobe;
        busy_d     = (ch_cnt_d != '0);
        sync_err_d = sync_err_q;
        if (clear) begin
            sync_err_d = 1'b0;
        end else if (resync) begin
            sync_err_d = 1'b1;
        end else begin
            sync_err_d = sync_err_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ch_cnt_q   <= '0;
            pending_q  <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            sync_err_q <= 1'b0;
            for (int i = 0; i < CHANNEL; i++) begin
                shadow_q[i] <= '0;
            end
            for (int i = 0; i < MAX_LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            ch_cnt_q   <= ch_cnt_d;
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            sync_err_q <= sync_err_d;
            for (int i = 0; i < CHANNEL; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            for (int i = 0; i < MAX_LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    channel_deserializer_16_frame_pixel_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_frame_pixel_counter (
        .clk    (clk),
        .resetn (resetn),
        .clear  (clear),
        .strobe (strobe),
        .done   (done)
    );

    assign data_out_0     = lane_q[0];
    assign data_out_1     = lane_q[1];
    assign data_out_2     = lane_q[2];
    assign data_out_3     = lane_q[3];
    assign data_out_4     = lane_q[4];
    assign data_out_5     = lane_q[5];
    assign data_out_6     = lane_q[6];
    assign data_out_7     = lane_q[7];
    assign data_out_8     = lane_q[8];
    assign data_out_9     = lane_q[9];
    assign data_out_10    = lane_q[10];
    assign data_out_11    = lane_q[11];
    assign data_out_12    = lane_q[12];
    assign data_out_13    = lane_q[13];
    assign data_out_14    = lane_q[14];
    assign data_out_15    = lane_q[15];
    assign data_valid_out = valid_q;
    assign busy           = busy_q;
    assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_channel_deserializer_16.sv
// Bench for channel_deserializer_16: a 16-channel and a 3-channel build on a
// 2x2 frame, checked cycle by cycle against a queue-based pixel model.
`timescale 1ns/1ps
module tb_channel_deserializer_16;
    import channel_deserializer_16_pkg::*;

    localparam int FRAME = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn16, resetn3, clear16, clear3;
    channel_deserializer_16_if #(.DATA_WIDTH(32)) if16 ();
    channel_deserializer_16_if #(.DATA_WIDTH(32)) if3 ();
    fp32_t lane16 [16];
    fp32_t lane3  [16];
    logic  v16, dn16, b16, s16, v3, dn3, b3, s3;

    channel_deserializer_16 #(.DATA_WIDTH(32), .IMG_WIDTH(2), .IMG_HEIGHT(2), .CHANNEL(16)) dut (
        .clk(clk), .resetn(resetn16), .clear(clear16), .in_if(if16),
        .data_out_0(lane16[0]),   .data_out_1(lane16[1]),   .data_out_2(lane16[2]),   .data_out_3(lane16[3]),
        .data_out_4(lane16[4]),   .data_out_5(lane16[5]),   .data_out_6(lane16[6]),   .data_out_7(lane16[7]),
        .data_out_8(lane16[8]),   .data_out_9(lane16[9]),   .data_out_10(lane16[10]), .data_out_11(lane16[11]),
        .data_out_12(lane16[12]), .data_out_13(lane16[13]), .data_out_14(lane16[14]), .data_out_15(lane16[15]),
        .data_valid_out(v16), .done(dn16), .busy(b16), .sync_err(s16)
    );

    channel_deserializer_16 #(.DATA_WIDTH(32), .IMG_WIDTH(2), .IMG_HEIGHT(2), .CHANNEL(3)) dut3 (
        .clk(clk), .resetn(resetn3), .clear(clear3), .in_if(if3),
        .data_out_0(lane3[0]),   .data_out_1(lane3[1]),   .data_out_2(lane3[2]),   .data_out_3(lane3[3]),
        .data_out_4(lane3[4]),   .data_out_5(lane3[5]),   .data_out_6(lane3[6]),   .data_out_7(lane3[7]),
        .data_out_8(lane3[8]),   .data_out_9(lane3[9]),   .data_out_10(lane3[10]), .data_out_11(lane3[11]),
        .data_out_12(lane3[12]), .data_out_13(lane3[13]), .data_out_14(lane3[14]), .data_out_15(lane3[15]),
        .data_valid_out(v3), .done(dn3), .busy(b3), .sync_err(s3)
    );

    // Which build is under test; observed outputs follow it.
    bit    sel = 1'b0;
    fp32_t obs_lane [16];
    logic  obs_valid, obs_done, obs_busy, obs_sync;
    always_comb begin
        for (int k = 0; k < 16; k++) obs_lane[k] = sel ? lane3[k] : lane16[k];
        obs_valid = sel ? v3  : v16;
        obs_done  = sel ? dn3 : dn16;
        obs_busy  = sel ? b3  : b16;
        obs_sync  = sel ? s3  : s16;
    end

    // Reference model: words of the pixel being gathered, the completed pixel
    // awaiting presentation, the presented lanes and the frame position.
    fp32_t m_part [$];
    fp32_t m_pend_pix [16];
    fp32_t m_lane [16];
    bit    m_pend, m_valid, m_done, m_busy, m_sync;
    int    m_pix;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic model_reset();
        m_part.delete();
        for (int k = 0; k < 16; k++) begin m_lane[k] = '0; m_pend_pix[k] = '0; end
        m_pend = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_sync = 1'b0; m_pix = 0;
    endtask

    task automatic model_edge(input bit v, input fp32_t d, input bit f, input bit clr);
        int ch = sel ? 3 : 16;
        m_valid = 1'b0;
        m_done  = 1'b0;
        if (m_pend && !clr) begin
            m_lane  = m_pend_pix;
            m_valid = 1'b1;
            m_done  = (m_pix == FRAME - 1);
            m_pix   = (m_pix + 1) % FRAME;
        end
        m_pend = 1'b0;
        if (clr) begin
            m_part.delete(); m_pix = 0; m_sync = 1'b0;
        end else if (v) begin
            if (f && m_part.size() != 0) begin m_sync = 1'b1; m_part.delete(); end
            m_part.push_back(d);
            if (m_part.size() == ch) begin
                for (int k = 0; k < 16; k++) m_pend_pix[k] = (k < ch) ? m_part[k] : 32'h0;
                m_pend = 1'b1;
                m_part.delete();
            end
        end
        m_busy = (m_part.size() != 0);
    endtask

    function automatic logic [3:0] ctl_obs();
        return {obs_valid, obs_done, obs_busy, obs_sync};
    endfunction
    function automatic logic [3:0] ctl_exp();
        return {m_valid, m_done, m_busy, m_sync};
    endfunction
    function automatic logic [511:0] lanes_obs();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = obs_lane[k];
        return r;
    endfunction
    function automatic logic [511:0] lanes_exp();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = m_lane[k];
        return r;
    endfunction

    // One clock of stimulus to the selected build; outputs sampled 1ns after the edge.
    task automatic step(input bit v, input fp32_t d, input bit f, input bit clr);
        if (sel) begin if3.in_valid = v; if3.in_data = d; if3.in_first = f; clear3 = clr; end
        else begin if16.in_valid = v; if16.in_data = d; if16.in_first = f; clear16 = clr; end
        @(posedge clk);
        model_edge(v, d, f, clr);
        #1;
        if3.in_valid = 1'b0; if3.in_data = '0; if3.in_first = 1'b0; clear3 = 1'b0;
        if16.in_valid = 1'b0; if16.in_data = '0; if16.in_first = 1'b0; clear16 = 1'b0;
    endtask

    task automatic test_reset();
        resetn16 = 1'b0; resetn3 = 1'b0; clear16 = 1'b0; clear3 = 1'b0;
        if16.in_valid = 1'b0; if16.in_data = '0; if16.in_first = 1'b0;
        if3.in_valid = 1'b0; if3.in_data = '0; if3.in_first = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            n_vec++; if (ctl_obs() !== 4'b0000) begin n_err++; $display("FAIL reset ctl build%0d got %b want 0000", s, ctl_obs()); end
            n_vec++; if (lanes_obs() !== 512'h0) begin n_err++; $display("FAIL reset lanes build%0d got %h want 0", s, lanes_obs()); end
        end
        sel = 1'b0;
        resetn16 = 1'b1; resetn3 = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_pixel();
        int ns = 0; int at = -1;
        for (int c = 0; c < 20; c++) begin
            if (c < 16) step(1'b1, 32'h3F800000 + c, (c == 0), 1'b0);
            else step(1'b0, '0, 1'b0, 1'b0);
            n_vec++; if (ctl_obs() !== ctl_exp()) begin n_err++; $display("FAIL single ctl cyc%0d got %b want %b", c, ctl_obs(), ctl_exp()); end
            n_vec++; if (lanes_obs() !== lanes_exp()) begin n_err++; $display("FAIL single lanes cyc%0d got %h want %h", c, lanes_obs(), lanes_exp()); end
            if (c < 15) begin
                n_vec++; if (obs_busy !== 1'b1) begin n_err++; $display("FAIL single busy cyc%0d got %b want 1", c, obs_busy); end
            end
            if (obs_valid === 1'b1) begin
                ns++; at = c;
                for (int k = 0; k < 16; k++) begin
                    n_vec++; if (obs_lane[k] !== 32'h3F800000 + k) begin n_err++; $display("FAIL single lane%0d got %h want %h", k, obs_lane[k], 32'h3F800000 + k); end
                end
            end
        end
        n_vec++; if (ns != 1 || at != 16) begin n_err++; $display("FAIL single strobe count/cycle got %0d@%0d want 1@16", ns, at); end
    endtask

    task automatic test_frame();
        int st [8]; bit dn [8]; int ns = 0;
        step(1'b0, '0, 1'b0, 1'b1);
        for (int c = 0; c < 84; c++) begin
            if (c < 80) step(1'b1, $urandom(), (c % 16 == 0), 1'b0);
            else step(1'b0, '0, 1'b0, 1'b0);
            n_vec++; if (ctl_obs() !== ctl_exp()) begin n_err++; $display("FAIL frame ctl cyc%0d got %b want %b", c, ctl_obs(), ctl_exp()); end
            n_vec++; if (lanes_obs() !== lanes_exp()) begin n_err++; $display("FAIL frame lanes cyc%0d got %h want %h", c, lanes_obs(), lanes_exp()); end
            if (obs_valid === 1'b1 && ns < 8) begin st[ns] = c; dn[ns] = obs_done; ns++; end
        end
        n_vec++; if (ns != 5) begin n_err++; $display("FAIL frame strobe count got %0d want 5", ns); end
        for (int i = 0; i < ns && i < 5; i++) begin
            n_vec++; if (st[i] != 16 * (i + 1) || dn[i] != (i == 3)) begin
                n_err++; $display("FAIL frame strobe%0d got cyc%0d done%0d want cyc%0d done%0d", i, st[i], dn[i], 16 * (i + 1), (i == 3));
            end
        end
    endtask

    task automatic test_gaps();
        int acc = 0; int c = 0; int ns = 0;
        step(1'b0, '0, 1'b0, 1'b1);
        while (acc < 48 && c < 400) begin
            bit v;
            v = ($urandom_range(0, 1) == 1);
            step(v, $urandom(), v && (acc % 16 == 0), 1'b0);
            if (v) acc++;
            c++;
            if (obs_valid === 1'b1) ns++;
            n_vec++; if (ctl_obs() !== ctl_exp()) begin n_err++; $display("FAIL gaps ctl cyc%0d got %b want %b", c, ctl_obs(), ctl_exp()); end
            n_vec++; if (lanes_obs() !== lanes_exp()) begin n_err++; $display("FAIL gaps lanes cyc%0d got %h want %h", c, lanes_obs(), lanes_exp()); end
        end
        n_vec++; if (acc < 48) begin n_err++; $display("FAIL gaps timeout got %0d words want 48", acc); end
        repeat (3) begin
            step(1'b0, '0, 1'b0, 1'b0);
            if (obs_valid === 1'b1) ns++;
            n_vec++; if (lanes_obs() !== lanes_exp()) begin n_err++; $display("FAIL gaps flush lanes got %h want %h", lanes_obs(), lanes_exp()); end
        end
        n_vec++; if (ns != 3) begin n_err++; $display("FAIL gaps strobe count got %0d want 3", ns); end
    endtask

    task automatic test_sync();
        fp32_t marker = $urandom();
        int ns = 0; int at = -1;
        step(1'b0, '0, 1'b0, 1'b1);
        for (int c = 0; c < 26; c++) begin
            if (c == 7) step(1'b1, marker, 1'b1, 1'b0);
            else if (c < 23) step(1'b1, $urandom(), (c == 0), 1'b0);
            else step(1'b0, '0, 1'b0, 1'b0);
            n_vec++; if (ctl_obs() !== ctl_exp()) begin n_err++; $display("FAIL sync ctl cyc%0d got %b want %b", c, ctl_obs(), ctl_exp()); end
            n_vec++; if (lanes_obs() !== lanes_exp()) begin n_err++; $display("FAIL sync lanes cyc%0d got %h want %h", c, lanes_obs(), lanes_exp()); end
            if (c >= 7) begin
                n_vec++; if (obs_sync !== 1'b1) begin n_err++; $display("FAIL sync sticky cyc%0d got %b want 1", c, obs_sync); end
            end
            if (obs_valid === 1'b1) begin
                ns++; at = c;
                n_vec++; if (obs_lane[0] !== marker) begin n_err++; $display("FAIL sync lane0 got %h want %h", obs_lane[0], marker); end
            end
        end
        n_vec++; if (ns != 1 || at != 23) begin n_err++; $display("FAIL sync strobe count/cycle got %0d@%0d want 1@23", ns, at); end
    endtask

    task automatic test_clear();
        int ns = 0; int dpos = -1;
        step(1'b0, '0, 1'b0, 1'b1);
        for (int c = 0; c < 23; c++) begin
            if (c == 5) step(1'b1, $urandom(), 1'b1, 1'b0);
            else if (c < 20) step(1'b1, $urandom(), 1'b0, 1'b0);
            else if (c == 20) step(1'b1, $urandom(), 1'b0, 1'b1);
            else step(1'b0, '0, 1'b0, 1'b0);
            n_vec++; if (ctl_obs() !== ctl_exp()) begin n_err++; $display("FAIL clear ctl cyc%0d got %b want %b", c, ctl_obs(), ctl_exp()); end
            n_vec++; if (lanes_obs() !== lanes_exp()) begin n_err++; $display("FAIL clear lanes cyc%0d got %h want %h", c, lanes_obs(), lanes_exp()); end
            if (c >= 20) begin
                n_vec++; if ({obs_valid, obs_busy, obs_sync} !== 3'b000) begin n_err++; $display("FAIL clear ch15 got v/b/s %b want 000", {obs_valid, obs_busy, obs_sync}); end
            end
        end
        for (int c = 0; c < 16; c++) step(1'b1, $urandom(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        n_vec++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL clear cancel got strobe %b want 0", obs_valid); end
        n_vec++; if (lanes_obs() !== lanes_exp()) begin n_err++; $display("FAIL clear cancel lanes got %h want %h", lanes_obs(), lanes_exp()); end
        for (int c = 0; c < 66; c++) begin
            if (c < 64) step(1'b1, $urandom(), (c % 16 == 0), 1'b0);
            else step(1'b0, '0, 1'b0, 1'b0);
            n_vec++; if (ctl_obs() !== ctl_exp()) begin n_err++; $display("FAIL clear restart ctl cyc%0d got %b want %b", c, ctl_obs(), ctl_exp()); end
            if (obs_valid === 1'b1) begin ns++; if (obs_done === 1'b1) dpos = ns; end
        end
        n_vec++; if (ns != 4 || dpos != 4) begin n_err++; $display("FAIL clear restart got %0d strobes done@%0d want 4 done@4", ns, dpos); end
    endtask

    task automatic test_ch3();
        int acc = 0; int c = 0; int ns = 0;
        fp32_t w;
        sel = 1'b1;
        model_reset();
        while (acc < 12 && c < 200) begin
            bit v;
            v = ($urandom_range(0, 1) == 1);
            step(v, $urandom(), 1'b0, 1'b0);
            if (v) acc++;
            c++;
            n_vec++; if (ctl_obs() !== ctl_exp()) begin n_err++; $display("FAIL ch3 ctl cyc%0d got %b want %b", c, ctl_obs(), ctl_exp()); end
            n_vec++; if (lanes_obs() !== lanes_exp()) begin n_err++; $display("FAIL ch3 lanes cyc%0d got %h want %h", c, lanes_obs(), lanes_exp()); end
            if (obs_valid === 1'b1) begin
                ns++;
                for (int k = 3; k < 16; k++) begin
                    n_vec++; if (obs_lane[k] !== 32'h0) begin n_err++; $display("FAIL ch3 lane%0d got %h want 0", k, obs_lane[k]); end
                end
            end
        end
        n_vec++; if (acc < 12) begin n_err++; $display("FAIL ch3 timeout got %0d words want 12", acc); end
        step(1'b0, '0, 1'b0, 1'b0);
        if (obs_valid === 1'b1) ns++;
        n_vec++; if (ns != 4) begin n_err++; $display("FAIL ch3 strobe count got %0d want 4", ns); end
        step(1'b1, $urandom(), 1'b0, 1'b0);
        step(1'b1, $urandom(), 1'b0, 1'b0);
        resetn3 = 1'b0;
        #1;
        n_vec++; if (ctl_obs() !== 4'b0000) begin n_err++; $display("FAIL ch3 async reset ctl got %b want 0000", ctl_obs()); end
        n_vec++; if (lanes_obs() !== 512'h0) begin n_err++; $display("FAIL ch3 async reset lanes got %h want 0", lanes_obs()); end
        model_reset();
        #1;
        resetn3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w = $urandom();
            if (i < 3) step(1'b1, w, 1'b0, 1'b0);
            else step(1'b0, '0, 1'b0, 1'b0);
            n_vec++; if (ctl_obs() !== ctl_exp()) begin n_err++; $display("FAIL ch3 post-reset ctl step%0d got %b want %b", i, ctl_obs(), ctl_exp()); end
            n_vec++; if (lanes_obs() !== lanes_exp()) begin n_err++; $display("FAIL ch3 post-reset lanes step%0d got %h want %h", i, lanes_obs(), lanes_exp()); end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_frame();
        test_gaps();
        test_sync();
        test_clear();
        test_ch3();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
